regwb_arb: RTL
==============

REGWB_ARB -- requirements
Module: regwb_arb

Interface
REQ-001 SHALL take parameter STARVE_MAX, default 3: consecutive refused cycles of requester 1 before it is forced a grant; legal range 1..15.
REQ-002 SHALL have port i_clk  input  1  the single core clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports i_req0_valid / o_req0_ready  input / output  1 / 1  requester 0 (execute stage) handshake.
REQ-005 SHALL have ports i_req0_waddr / i_req0_wdata  input  `REG_ADDRW / `CPU_WIDTH  requester 0 destination register and data.
REQ-006 SHALL have ports i_req1_valid / o_req1_ready  input / output  1 / 1  requester 1 (multi-cycle LSU/MDU) handshake.
REQ-007 SHALL have ports i_req1_waddr / i_req1_wdata  input  `REG_ADDRW / `CPU_WIDTH  requester 1 destination register and data.
REQ-008 SHALL have ports o_rf_wen / o_rf_waddr / o_rf_wdata  output  1 / `REG_ADDRW / `CPU_WIDTH  registered drive of the register-file write port.
REQ-009 SHALL have ports i_raddr1 / i_raddr2  input  `REG_ADDRW  decode-stage read addresses, used for forwarding.
REQ-010 SHALL have ports o_fwd1_hit / o_fwd2_hit  output  1  pending write matches the read address; o_fwd_data  output  `CPU_WIDTH  forwarded value.

Function
REQ-011 SHALL transfer on requester N when valid & ready are high in the same cycle; requesters hold valid, waddr and wdata stable until ready.
REQ-012 SHALL grant at most one requester per cycle; ready is combinational from both valids and the starvation state only.
REQ-013 SHALL use default priority requester 0 > requester 1.
REQ-014 SHALL keep a starvation counter: +1 each cycle req1 is valid and not granted; cleared on a req1 grant or when req1 is not valid; saturates at STARVE_MAX.
REQ-015 SHALL grant requester 1, with o_req0_ready low, in any cycle the counter equals STARVE_MAX and req1 is valid.
REQ-016 SHALL register the granted transfer: cycle after the transfer, o_rf_wen=1, o_rf_waddr/o_rf_wdata = accepted values (latency 1).
REQ-017 SHALL drive o_rf_wen=0 in the cycle after a transfer with waddr==0; the handshake still completes (x0 writes are silently dropped).
REQ-018 SHALL drive o_rf_wen=0 in the cycle after any cycle with no transfer; o_rf_waddr/o_rf_wdata hold their previous values.
REQ-019 SHALL accept back-to-back transfers every cycle; no bubble between grants.

Reset
REQ-020 SHALL, on i_rst high at a clock edge, clear o_rf_wen, o_rf_waddr, o_rf_wdata and the starvation counter to 0.
REQ-021 SHALL hold o_req0_ready and o_req1_ready low while i_rst is high; a transfer in flight when reset asserts is discarded and is not written.

Configuration
REQ-022 SHALL, with macro REGWB_FWD_EN defined: o_fwdK_hit = o_rf_wen & (o_rf_waddr == i_raddrK) & (i_raddrK != 0); o_fwd_data = o_rf_wdata.
REQ-023 SHALL, with REGWB_FWD_EN undefined: o_fwd1_hit, o_fwd2_hit and o_fwd_data tied to 0; the port list is unchanged.

Structure
REQ-024 SHALL take `CPU_WIDTH and `REG_ADDRW from the shared config include; the grant enum (GNT_NONE, GNT_REQ0, GNT_REQ1) SHALL live in the shared core package.
REQ-025 SHALL place fixed-priority and starvation-override grant selection in one sub-module, regwb_grant, containing the counter; regwb_arb holds the output register and the forwarding logic.

Verification
REQ-026 SHALL cover: req0 only, waddr=5, wdata=0x1234 -> ready0=1 same cycle; next cycle wen=1, waddr=5, wdata=0x1234.
REQ-027 SHALL cover: req0 and req1 both valid continuously, STARVE_MAX=3 -> req0 granted 3 cycles, req1 granted on the 4th, counter returns to 0.
REQ-028 SHALL cover: req1 only, waddr=0, wdata=0xFFFF -> ready1=1; next cycle wen=0.
REQ-029 SHALL cover: i_rst pulsed the cycle after a transfer to x7 -> wen=0, counter=0; x7 is never written.
REQ-030 SHALL cover forwarding: transfer to x10 with wdata=0xA, i_raddr1=10 next cycle -> with REGWB_FWD_EN, fwd1_hit=1 and fwd_data=0xA; without the macro, fwd1_hit=0.
REQ-031 SHALL cover: alternating req0 and req1 each cycle -> one write per cycle, order preserved, no bubbles.

Source files
------------

// File: rtl/regwb_arb_pkg.sv
// +------------------------------------------------------------------+
// | regwb_arb_pkg : shared widths and grant encoding for regwb_arb     |
// | rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif

package regwb_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REQ0 = 2'd1,
    GNT_REQ1 = 2'd2
  } gnt_e;

  // Wide enough for the largest legal STARVE_MAX (15).
  localparam int unsigned CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/regwb_grant.sv
// +------------------------------------------------------------------+
// | regwb_grant : fixed-priority grant with req1 starvation override   |
// | rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module regwb_grant
  import regwb_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req0_valid,
  input  logic i_req1_valid,
  output logic o_req0_ready,
  output logic o_req1_ready,
  output gnt_e o_gnt
);

  localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             force1;

  // Once req1 has waited STARVE_MAX cycles it wins over req0.
  assign force1 = i_req1_valid && (cnt_q == C_STARVE_MAX);

  always_comb begin
    o_req0_ready = !i_rst && !force1;
    o_req1_ready = !i_rst && (force1 || !i_req0_valid);
    if (i_req0_valid && o_req0_ready) begin
      o_gnt = GNT_REQ0;
    end else if (i_req1_valid && o_req1_ready) begin
      o_gnt = GNT_REQ1;
    end else begin
      o_gnt = GNT_NONE;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!i_req1_valid || (o_gnt == GNT_REQ1)) begin
      cnt_d = '0;
    end else if (cnt_q != C_STARVE_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regwb_arb.sv
// +------------------------------------------------------------------+
// | regwb_arb : two-requester register-file write-back arbiter         |
// | optional forwarding with macro REGWB_FWD_EN ; rev 1.0              |
// +------------------------------------------------------------------+
`default_nettype none

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif

module regwb_arb
  import regwb_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [`REG_ADDRW-1:0] i_req0_waddr,
  input  logic [`CPU_WIDTH-1:0] i_req0_wdata,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [`REG_ADDRW-1:0] i_req1_waddr,
  input  logic [`CPU_WIDTH-1:0] i_req1_wdata,
  output logic                  o_rf_wen,
  output logic [`REG_ADDRW-1:0] o_rf_waddr,
  output logic [`CPU_WIDTH-1:0] o_rf_wdata,
  input  logic [`REG_ADDRW-1:0] i_raddr1,
  input  logic [`REG_ADDRW-1:0] i_raddr2,
  output logic                  o_fwd1_hit,
  output logic                  o_fwd2_hit,
  output logic [`CPU_WIDTH-1:0] o_fwd_data
);

  gnt_e                  gnt;
  logic                  rf_wen_q,   rf_wen_d;
  logic [`REG_ADDRW-1:0] rf_waddr_q, rf_waddr_d;
  logic [`CPU_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  regwb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req0_valid (i_req0_valid),
    .i_req1_valid (i_req1_valid),
    .o_req0_ready (o_req0_ready),
    .o_req1_ready (o_req1_ready),
    .o_gnt        (gnt)
  );

  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    case (gnt)
      GNT_REQ0: begin
        rf_wen_d   = (i_req0_waddr != '0);
        rf_waddr_d = i_req0_waddr;
        rf_wdata_d = i_req0_wdata;
      end
      GNT_REQ1: begin
        rf_wen_d   = (i_req1_waddr != '0);
        rf_waddr_d = i_req1_waddr;
        rf_wdata_d = i_req1_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Masking with reset drops a write already sitting in the output register.
  assign o_rf_wen   = rf_wen_q & ~i_rst;
  assign o_rf_waddr = rf_waddr_q;
  assign o_rf_wdata = rf_wdata_q;

`ifdef REGWB_FWD_EN
  assign o_fwd1_hit = o_rf_wen && (o_rf_waddr == i_raddr1) && (i_raddr1 != '0);
  assign o_fwd2_hit = o_rf_wen && (o_rf_waddr == i_raddr2) && (i_raddr2 != '0);
  assign o_fwd_data = o_rf_wdata;
`else
  logic unused_raddr;
  assign unused_raddr = ^{i_raddr1, i_raddr2};
  assign o_fwd1_hit   = 1'b0;
  assign o_fwd2_hit   = 1'b0;
  assign o_fwd_data   = '0;
`endif

endmodule

`default_nettype wire
